// File: rtl/fdtd_pkg.sv
// fdtd_pkg: shared widths and arithmetic helpers for the FDTD field-update pipe.
//   diff_w/prod_w/sum_w : derived widths (DIFF_W = DW+1, PROD_W = DW+CW+1, SUM_W = DW+CW+2)
//   rnd_const           : round-half-up bias 2^(FRAC-1), or 0 when truncating
//   sat_dw / sat_hit    : clamp a wide signed value to a DW-bit signed range
// Helpers work on a fixed MAX_W-bit carrier so they serve any DW/CW/FRAC instance;
// callers sign-extend into the carrier and size-cast the result back.
package fdtd_pkg;

    localparam int MAX_W = 128;

    function automatic int diff_w(input int dw);
        return dw + 1;
    endfunction

    function automatic int prod_w(input int dw, input int cw);
        return dw + cw + 1;
    endfunction

    function automatic int sum_w(input int dw, input int cw);
        return dw + cw + 2;
    endfunction

    function automatic logic [MAX_W-1:0] rnd_const(input int frac, input int rnd);
        logic [MAX_W-1:0] r;
        r = '0;
        if (rnd != 0 && frac > 0) begin
            r = {{(MAX_W-1){1'b0}}, 1'b1} << (frac - 1);
        end
        return r;
    endfunction

    function automatic logic signed [MAX_W-1:0] sat_max(input int dw);
        logic [MAX_W-1:0] one;
        one = {{(MAX_W-1){1'b0}}, 1'b1};
        return $signed((one << (dw - 1)) - one);
    endfunction

    function automatic logic signed [MAX_W-1:0] sat_dw(input logic signed [MAX_W-1:0] x,
                                                       input int dw);
        logic signed [MAX_W-1:0] hi;
        logic signed [MAX_W-1:0] lo;
        hi = sat_max(dw);
        lo = ~hi;
        if (x > hi) begin
            return hi;
        end else if (x < lo) begin
            return lo;
        end
        return x;
    endfunction

    function automatic logic sat_hit(input logic signed [MAX_W-1:0] x, input int dw);
        logic signed [MAX_W-1:0] hi;
        hi = sat_max(dw);
        return (x > hi) || (x < ~hi);
    endfunction

endpackage

// File: rtl/fdtd_round_shift.sv
// fdtd_round_shift: combinational optional round-half-up, then arithmetic shift right by FRAC.
//   p_i : signed product, IW bits
//   s_o : signed scaled result, sign-extended to OW bits (OW >= IW+1)
// One guard bit is added before biasing so the rounding add can never wrap.
module fdtd_round_shift
    import fdtd_pkg::*;
#(
    parameter int IW    = 65,
    parameter int OW    = 66,
    parameter int FRAC  = 21,
    parameter int ROUND = 1
) (
    input  logic signed [IW-1:0] p_i,
    output logic signed [OW-1:0] s_o
);

    localparam int RW = IW + 1;
    localparam logic [RW-1:0] RC = RW'(rnd_const(FRAC, ROUND));

    logic signed [RW-1:0] biased;
    logic signed [RW-1:0] shifted;

    always_comb begin
        biased  = {p_i[IW-1], p_i} + $signed(RC);
        shifted = biased >>> FRAC;
    end

    generate
        if (OW > RW) begin : g_ext
            assign s_o = {{(OW-RW){shifted[RW-1]}}, shifted};
        end else begin : g_eq
            assign s_o = shifted;
        end
    endgenerate

endmodule

// File: rtl/fdtd_field_update_pipe.sv
// fdtd_field_update_pipe: streaming FDTD update, one field sample per beat:
//   f_new = sat( rnd(f_old*c_self) +/- rnd((curl - curl_prev)*c_curl) )
// Ports:
//   CLK, RST_N                     clock, async active-low reset
//   in_valid_i / in_ready_o        input handshake
//   sol_i                          start of line: previous curl sample taken as 0
//   f_old_i, curl_i                field data (DW, signed)
//   c_self_i, c_curl_i             coefficients (CW, signed, FRAC fractional bits)
//   curl_sign_i                    1 = subtract the curl term
//   out_valid_o / out_ready_i      output handshake
//   f_new_o, sat_o                 result and per-beat saturation flag
//   sat_sticky_o, sat_clr_i        sticky saturation flag and its synchronous clear
// Four register stages (S0 diff, S1 products, S2 sum, S3 output) share one advance
// enable, so a beat is valid three edges after its accept and bubbles are kept.
module fdtd_field_update_pipe
    import fdtd_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CW    = 32,
    parameter int FRAC  = 21,
    parameter int ROUND = 1
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          in_valid_i,
    output logic          in_ready_o,
    input  logic          sol_i,
    input  logic [DW-1:0] f_old_i,
    input  logic [DW-1:0] curl_i,
    input  logic [CW-1:0] c_self_i,
    input  logic [CW-1:0] c_curl_i,
    input  logic          curl_sign_i,
    output logic          out_valid_o,
    input  logic          out_ready_i,
    output logic [DW-1:0] f_new_o,
    output logic          sat_o,
    output logic          sat_sticky_o,
    input  logic          sat_clr_i
);

    localparam int DIFF_W  = diff_w(DW);
    localparam int PROD_W  = prod_w(DW, CW);
    localparam int PSELF_W = DW + CW;
    localparam int SUM_W   = sum_w(DW, CW);

    logic adv;

    logic                v0_q, v0_d, v1_q, v1_d, v2_q, v2_d, out_valid_q, out_valid_d;
    logic [DIFF_W-1:0]   diff_q, diff_d;
    logic [DW-1:0]       f_old_q, f_old_d, curl_prev_q, curl_prev_d;
    logic [CW-1:0]       c_self_q, c_self_d, c_curl_q, c_curl_d;
    logic                sign0_q, sign0_d, sign1_q, sign1_d;
    logic [PROD_W-1:0]   p_curl_q, p_curl_d;
    logic [PSELF_W-1:0]  p_self_q, p_self_d;
    logic [SUM_W-1:0]    sum_q, sum_d;
    logic [DW-1:0]       f_new_q, f_new_d;
    logic                sat_q, sat_d, sat_sticky_q, sat_sticky_d;

    logic signed [SUM_W-1:0] s_self, s_curl;
    logic signed [MAX_W-1:0] sum_ext;

    fdtd_round_shift #(.IW(PSELF_W), .OW(SUM_W), .FRAC(FRAC), .ROUND(ROUND)) u_rs_self (
        .p_i (p_self_q),
        .s_o (s_self)
    );

    fdtd_round_shift #(.IW(PROD_W), .OW(SUM_W), .FRAC(FRAC), .ROUND(ROUND)) u_rs_curl (
        .p_i (p_curl_q),
        .s_o (s_curl)
    );

    assign adv        = !out_valid_q | out_ready_i;
    assign in_ready_o = adv;

    always_comb begin
        v0_d         = v0_q;
        v1_d         = v1_q;
        v2_d         = v2_q;
        out_valid_d  = out_valid_q;
        diff_d       = diff_q;
        f_old_d      = f_old_q;
        c_self_d     = c_self_q;
        c_curl_d     = c_curl_q;
        sign0_d      = sign0_q;
        curl_prev_d  = curl_prev_q;
        p_curl_d     = p_curl_q;
        p_self_d     = p_self_q;
        sign1_d      = sign1_q;
        sum_d        = sum_q;
        f_new_d      = f_new_q;
        sat_d        = sat_q;
        sum_ext      = {{(MAX_W-SUM_W){sum_q[SUM_W-1]}}, sum_q};

        if (adv) begin
            v0_d        = in_valid_i;
            v1_d        = v0_q;
            v2_d        = v1_q;
            out_valid_d = v2_q;
            sat_d       = v2_q & sat_hit(sum_ext, DW);

            if (in_valid_i) begin
                diff_d      = {curl_i[DW-1], curl_i}
                              - (sol_i ? '0 : {curl_prev_q[DW-1], curl_prev_q});
                f_old_d     = f_old_i;
                c_self_d    = c_self_i;
                c_curl_d    = c_curl_i;
                sign0_d     = curl_sign_i;
                curl_prev_d = curl_i;
            end

            if (v0_q) begin
                p_curl_d = $signed({{CW{diff_q[DIFF_W-1]}}, diff_q})
                         * $signed({{DIFF_W{c_curl_q[CW-1]}}, c_curl_q});
                p_self_d = $signed({{CW{f_old_q[DW-1]}}, f_old_q})
                         * $signed({{DW{c_self_q[CW-1]}}, c_self_q});
                sign1_d  = sign0_q;
            end

            if (v1_q) begin
                sum_d = s_self + (sign1_q ? -s_curl : s_curl);
            end

            // f_new_o keeps the last real result across bubbles.
            if (v2_q) begin
                f_new_d = DW'(sat_dw(sum_ext, DW));
            end
        end

        // A saturated transfer in the same cycle as a clear leaves the flag set.
        sat_sticky_d = sat_sticky_q & !sat_clr_i;
        if (out_valid_q & out_ready_i & sat_q) begin
            sat_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            v0_q         <= 1'b0;
            v1_q         <= 1'b0;
            v2_q         <= 1'b0;
            out_valid_q  <= 1'b0;
            diff_q       <= '0;
            f_old_q      <= '0;
            c_self_q     <= '0;
            c_curl_q     <= '0;
            sign0_q      <= 1'b0;
            curl_prev_q  <= '0;
            p_curl_q     <= '0;
            p_self_q     <= '0;
            sign1_q      <= 1'b0;
            sum_q        <= '0;
            f_new_q      <= '0;
            sat_q        <= 1'b0;
            sat_sticky_q <= 1'b0;
        end else begin
            v0_q         <= v0_d;
            v1_q         <= v1_d;
            v2_q         <= v2_d;
            out_valid_q  <= out_valid_d;
            diff_q       <= diff_d;
            f_old_q      <= f_old_d;
            c_self_q     <= c_self_d;
            c_curl_q     <= c_curl_d;
            sign0_q      <= sign0_d;
            curl_prev_q  <= curl_prev_d;
            p_curl_q     <= p_curl_d;
            p_self_q     <= p_self_d;
            sign1_q      <= sign1_d;
            sum_q        <= sum_d;
            f_new_q      <= f_new_d;
            sat_q        <= sat_d;
            sat_sticky_q <= sat_sticky_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign f_new_o      = f_new_q;
    assign sat_o        = sat_q;
    assign sat_sticky_o = sat_sticky_q;

endmodule

// File: tb/tb_fdtd_field_update_pipe.sv
// Directed bench for fdtd_field_update_pipe at DW=CW=16, FRAC=8.
// A second instance with ROUND=0 shares all inputs to observe truncation.
module tb_fdtd_field_update_pipe;

    logic               CLK = 1'b0;
    logic               RST_N;
    logic               in_valid, sol, sign, out_ready, sat_clr;
    logic signed [15:0] curl, f_old, c_self, c_curl;

    logic               in_ready, out_valid, sat, sticky;
    logic signed [15:0] f_new;
    logic               in_ready_t, out_valid_t, sat_t, sticky_t;
    logic signed [15:0] f_new_t;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    fdtd_field_update_pipe #(.DW(16), .CW(16), .FRAC(8), .ROUND(1)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .sol_i(sol),
        .f_old_i(f_old), .curl_i(curl), .c_self_i(c_self), .c_curl_i(c_curl),
        .curl_sign_i(sign), .out_valid_o(out_valid), .out_ready_i(out_ready),
        .f_new_o(f_new), .sat_o(sat), .sat_sticky_o(sticky), .sat_clr_i(sat_clr)
    );

    fdtd_field_update_pipe #(.DW(16), .CW(16), .FRAC(8), .ROUND(0)) dut_trunc (
        .CLK(CLK), .RST_N(RST_N),
        .in_valid_i(in_valid), .in_ready_o(in_ready_t), .sol_i(sol),
        .f_old_i(f_old), .curl_i(curl), .c_self_i(c_self), .c_curl_i(c_curl),
        .curl_sign_i(sign), .out_valid_o(out_valid_t), .out_ready_i(out_ready),
        .f_new_o(f_new_t), .sat_o(sat_t), .sat_sticky_o(sticky_t), .sat_clr_i(sat_clr)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_beat(input bit sol_v, input int cu, input int fo, input int cs,
                            input int cc, input bit sg);
        in_valid = 1'b1;
        sol      = sol_v;
        curl     = 16'(cu);
        f_old    = 16'(fo);
        c_self   = 16'(cs);
        c_curl   = 16'(cc);
        sign     = sg;
    endtask

    // Presents one beat, then returns at the sample point after its output edge.
    task automatic one_beat(input bit sol_v, input int cu, input int fo, input int cs,
                            input int cc, input bit sg);
        set_beat(sol_v, cu, fo, cs, cc, sg);
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (3) @(negedge CLK);
    endtask

    task automatic stream_pair(input bit sg, input int e1, input int e2);
        set_beat(1'b1, 10, 100, 256, 128, sg);
        @(negedge CLK);
        set_beat(1'b0, 30, 100, 256, 128, sg);
        @(negedge CLK);
        in_valid = 1'b0;
        check_val("pair_lat1_valid", int'(out_valid), 0);
        @(negedge CLK);
        check_val("pair_lat2_valid", int'(out_valid), 0);
        @(negedge CLK);
        check_val("pair_b1_valid", int'(out_valid), 1);
        check_val("pair_b1_data", int'(f_new), e1);
        @(negedge CLK);
        check_val("pair_b2_valid", int'(out_valid), 1);
        check_val("pair_b2_data", int'(f_new), e2);
        @(negedge CLK);
        check_val("pair_end_valid", int'(out_valid), 0);
    endtask

    function automatic void model(input int fo, input int cu, input int prev, input bit sol_v,
                                  input int cs, input int cc, input bit sg,
                                  output int res, output bit sat_v);
        longint d, ps, pc, ss, sc, sm;
        d  = longint'(cu) - (sol_v ? 64'sd0 : longint'(prev));
        ps = longint'(fo) * longint'(cs);
        pc = d * longint'(cc);
        ss = (ps + 128) >>> 8;
        sc = (pc + 128) >>> 8;
        sm = sg ? ss - sc : ss + sc;
        sat_v = 1'b0;
        if (sm > 32767) begin
            sm = 32767;
            sat_v = 1'b1;
        end else if (sm < -32768) begin
            sm = -32768;
            sat_v = 1'b1;
        end
        res = int'(sm);
    endfunction

    int  bfo[20], bcu[20], bcs[20], bcc[20], exp_v[20];
    bit  bsol[20], bsg[20], exp_s[20];
    int  prev, in_idx, out_idx, cyc;
    bit  take_in, take_out;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST_N = 1'b0; in_valid = 1'b0; sol = 1'b0; sign = 1'b0;
        curl = '0; f_old = '0; c_self = '0; c_curl = '0;
        out_ready = 1'b1; sat_clr = 1'b0;
        repeat (2) @(negedge CLK);
        check_val("rst_out_valid", int'(out_valid), 0);
        check_val("rst_f_new", int'(f_new), 0);
        check_val("rst_sat", int'(sat), 0);
        check_val("rst_sticky", int'(sticky), 0);
        RST_N = 1'b1;
        @(negedge CLK);
        check_val("rst_in_ready", int'(in_ready), 1);

        stream_pair(1'b0, 105, 110);
        stream_pair(1'b1, 95, 90);

        one_beat(1'b1, 128, 0, 256, 1, 1'b0);
        check_val("rnd_pos_valid", int'(out_valid), 1);
        check_val("rnd_pos", int'(f_new), 1);
        check_val("trunc_pos", int'(f_new_t), 0);
        check_val("rnd_pos_sat", int'(sat), 0);
        @(negedge CLK);
        one_beat(1'b1, -128, 0, 256, 1, 1'b0);
        check_val("rnd_neg", int'(f_new), 0);
        check_val("trunc_neg", int'(f_new_t), -1);
        @(negedge CLK);

        one_beat(1'b1, 256, 32767, 256, 256, 1'b0);
        check_val("sat_pos_data", int'(f_new), 32767);
        check_val("sat_pos_flag", int'(sat), 1);
        check_val("sat_sticky_pre", int'(sticky), 0);
        @(negedge CLK);
        check_val("sat_sticky_set", int'(sticky), 1);
        check_val("sat_flag_idle", int'(sat), 0);
        one_beat(1'b1, 256, -32768, 256, 256, 1'b1);
        check_val("sat_neg_data", int'(f_new), -32768);
        check_val("sat_neg_flag", int'(sat), 1);
        sat_clr = 1'b1;
        @(negedge CLK);
        check_val("sat_set_wins", int'(sticky), 1);
        @(negedge CLK);
        check_val("sat_cleared", int'(sticky), 0);
        sat_clr = 1'b0;

        prev = 0;
        for (int i = 0; i < 20; i++) begin
            bfo[i]  = i * 1500 - 14000;
            bcu[i]  = i * i * 37 - 4000;
            bcs[i]  = 200 + i * 20;
            bcc[i]  = (i % 2 == 1) ? -200 : 180;
            bsg[i]  = (i % 3 == 0);
            bsol[i] = (i == 0) || (i == 9);
            model(bfo[i], bcu[i], prev, bsol[i], bcs[i], bcc[i], bsg[i], exp_v[i], exp_s[i]);
            prev = bcu[i];
        end
        in_idx = 0; out_idx = 0; cyc = 0;
        while (out_idx < 20 && cyc < 400) begin
            out_ready = (cyc % 3 == 0);
            if (in_idx < 20)
                set_beat(bsol[in_idx], bcu[in_idx], bfo[in_idx], bcs[in_idx], bcc[in_idx],
                         bsg[in_idx]);
            else
                in_valid = 1'b0;
            #1;
            if (out_valid && !out_ready)
                check_val("bp_in_ready_stall", int'(in_ready), 0);
            if (out_valid) begin
                check_val("bp_data", int'(f_new), exp_v[out_idx]);
                check_val("bp_sat", int'(sat), int'(exp_s[out_idx]));
            end
            take_in  = in_valid && in_ready;
            take_out = out_valid && out_ready;
            @(negedge CLK);
            if (take_in) in_idx++;
            if (take_out) out_idx++;
            cyc++;
        end
        check_val("bp_out_count", out_idx, 20);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            check_val("bp_no_extra", int'(out_valid), 0);
        end

        for (int i = 0; i < 4; i++) begin
            set_beat(i == 0, 1000 + i * 10, 500, 256, 256, 1'b0);
            @(negedge CLK);
        end
        in_valid = 1'b0;
        check_val("rstmid_pre_valid", int'(out_valid), 1);
        RST_N = 1'b0;
        #1;
        check_val("rstmid_valid", int'(out_valid), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            check_val("rstmid_flushed", int'(out_valid), 0);
        end
        one_beat(1'b0, 50, 0, 0, 256, 1'b0);
        check_val("rstmid_next_valid", int'(out_valid), 1);
        check_val("rstmid_next_data", int'(f_new), 50);
        @(negedge CLK);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fdtd_field_update_pipe.md
Name: fdtd_field_update_pipe

Overview:
Streaming, parametrised FDTD field-update engine for one field component per beat: F_new = sat( rnd(F_old*c_self) ± rnd((curl_i - curl_prev)*c_curl) ). It generalises the fixed-width Hy calculator with five additions: a valid/ready handshake with backpressure, a configurable fixed-point cut, rounding, saturation, and a runtime curl sign. This lets one instance serve Hx, Hy or Ez. It sits between the field-memory read streamer and the write-back streamer in the FDTD plugin.

Parameters:
DW, 32, signed width of field data (f_old_i, curl_i, f_new_o)
CW, 32, signed width of coefficients (c_self_i, c_curl_i)
FRAC, 21, fractional bits of coefficients; products are shifted right arithmetically by FRAC
ROUND, 1, 1 = round-half-up before the shift (add 2^(FRAC-1)); 0 = truncate

Ports:
CLK  in  1  clock
RST_N  in  1  asynchronous active-low reset
in_valid_i  in  1  input beat valid
in_ready_o  out  1  input beat accepted when in_valid_i & in_ready_o
sol_i  in  1  start-of-line; previous curl sample is treated as 0 (boundary)
f_old_i  in  DW  old value of the field being updated
curl_i  in  DW  current sample of the curl-source field
c_self_i  in  CW  self coefficient (e.g. chyh)
c_curl_i  in  CW  curl coefficient (e.g. chyez)
curl_sign_i  in  1  0 = add curl term, 1 = subtract curl term
out_valid_o  out  1  output beat valid
out_ready_i  in  1  downstream ready
f_new_o  out  DW  updated field value
sat_o  out  1  this output beat was saturated
sat_sticky_o  out  1  OR of sat_o since reset or last clear
sat_clr_i  in  1  synchronous clear of sat_sticky_o

Behaviour:
- Reset (async, RST_N=0): all stage valids = 0, out_valid_o = 0, f_new_o = 0, sat_o = 0, sat_sticky_o = 0, curl_prev = 0. in_ready_o = 1 after reset.
- Global advance enable: adv = !out_valid_o | out_ready_i. in_ready_o = adv. All stages move only when adv = 1. Stage bubbles do not compress.
- Latency is 3 adv-cycles. A beat accepted at edge t appears with out_valid_o = 1 after edge t+3, provided adv stays 1.
- S0, at the accept edge:
  - Register diff = curl_i - (sol_i ? 0 : curl_prev), width DW+1.
  - Register f_old_i, both coefficients and curl_sign_i.
  - Update curl_prev <= curl_i.
  - curl_prev changes only on accepted beats.
- S1:
  - p_curl = diff*c_curl, width DW+CW+1.
  - p_self = f_old*c_self, width DW+CW.
  - Both signed, full precision, no truncation.
- S2:
  - s_x = (p_x + (ROUND ? 2^(FRAC-1) : 0)) >>> FRAC.
  - sum = s_self + (sign ? -s_curl : s_curl), width DW+CW+2.
- S3 (output register):
  - f_new_o = sum clamped to [-2^(DW-1), 2^(DW-1)-1].
  - sat_o = 1 iff a clamp occurred.
  - sat_o is qualified by out_valid_o.
- While out_valid_o = 1 and out_ready_i = 0, f_new_o and sat_o hold stable. No beat is lost or duplicated.
- sat_sticky_o is set on a transfer (out_valid_o & out_ready_i & sat_o). If sat_clr_i coincides with a saturated transfer, set wins.
- sol_i is sampled only on an accepted beat. in_valid_i = 0 cycles do not affect curl_prev.
- Reset mid-operation flushes all in-flight beats; nothing is output for them.

Decomposition:
- Package fdtd_pkg: the saturate-to-DW function, the rounding constant function, and the localparam widths (DIFF_W = DW+1, PROD_W = DW+CW+1, SUM_W = DW+CW+2).
- One sub-module, fdtd_round_shift: combinational round plus arithmetic shift by FRAC. It is instantiated twice in S2.
- Multipliers are inferred, not vendor IP. The pipeline register stage absorbs DSP registering.

Test Plan:
All scenarios use DW=16, CW=16, FRAC=8, ROUND=1.
- Basic stream: c_self=256, c_curl=128, f_old=100 for both beats, sign=0, beats (sol=1, curl=10), (sol=0, curl=30), out_ready=1 -> outputs 105, 110; each valid exactly 3 cycles after its accept.
- Curl sign: same stream with sign=1 -> outputs 95, 90.
- Rounding: f_old=0, c_curl=1, sol=1, curl=128 -> 1; curl=-128 (sol=1) -> 0; with ROUND=0, curl=128 -> 0.
- Saturation: f_old=32767, c_self=256, c_curl=256, sol=1, curl=256 -> f_new=32767, sat_o=1, sat_sticky_o=1. The negative mirror (-32768, sign=1) -> -32768, sat_o=1. Pulsing sat_clr_i -> sticky = 0.
- Backpressure: 20 consecutive beats with out_ready toggled 1,0,0,1,0,... -> in_ready_o = 0 whenever output is stalled. The output sequence exactly matches the reference model, with f_new_o stable during stalls.
- Reset mid-stream: assert RST_N=0 with 3 beats in flight -> out_valid_o = 0 immediately and no flushed beat appears. Next beat with sol=0, curl=50, c_curl=256, f_old=0 -> 50 (curl_prev cleared to 0).
